// File: rtl/hdmi_packet_pkg.sv
// hdmi_packet_pkg: shared HDMI data-island packet type codes and InfoFrame indices.
//   PKT_*  : 8-bit HDMI packet header type codes handed to the packet assembler
//   IF_*   : bit positions of each InfoFrame in pending/grant vectors
//   WIN_*  : bit positions in the one-hot winner vector of the priority selector
package hdmi_packet_pkg;

    typedef logic [7:0] pkt_type_t;

    localparam pkt_type_t PKT_NULL         = 8'h00;
    localparam pkt_type_t PKT_ACR          = 8'h01;
    localparam pkt_type_t PKT_AUDIO_SAMPLE = 8'h02;
    localparam pkt_type_t PKT_AVI_IF       = 8'h82;
    localparam pkt_type_t PKT_SPD_IF       = 8'h83;
    localparam pkt_type_t PKT_AUDIO_IF     = 8'h84;

    localparam int IF_AVI      = 0;
    localparam int IF_SPD      = 1;
    localparam int IF_AUDIO_IF = 2;

    // Winner vector: [0] ACR, [1] audio sample, [4:2] InfoFrames in IF_* order
    localparam int WIN_ACR     = 0;
    localparam int WIN_AUDIO   = 1;
    localparam int WIN_IF_BASE = 2;

endpackage

// File: rtl/packet_priority_select.sv
// packet_priority_select: combinational fixed-priority pick of the next data-island packet.
//   acr_pending  : ACR request outstanding
//   audio_valid  : audio sample packet available
//   burst_limit  : audio burst exhausted while an InfoFrame waits, so audio is skipped
//   if_pending   : pending InfoFrames, indexed by IF_*
//   winner       : one-hot winner, indexed by WIN_* (all zero for a null slot)
//   pkt_type     : HDMI packet type code of the winner
module packet_priority_select
    import hdmi_packet_pkg::*;
(
    input  logic       acr_pending,
    input  logic       audio_valid,
    input  logic       burst_limit,
    input  logic [2:0] if_pending,
    output logic [4:0] winner,
    output pkt_type_t  pkt_type
);

    logic audio_ok;

    assign audio_ok = audio_valid && !burst_limit;

    // InfoFrame order is AVI, audio InfoFrame, SPD
    always_comb begin
        winner   = acr_pending             ? 5'b00001 << WIN_ACR :
                   audio_ok                ? 5'b00001 << WIN_AUDIO :
                   if_pending[IF_AVI]      ? 5'b00001 << (WIN_IF_BASE + IF_AVI) :
                   if_pending[IF_AUDIO_IF] ? 5'b00001 << (WIN_IF_BASE + IF_AUDIO_IF) :
                   if_pending[IF_SPD]      ? 5'b00001 << (WIN_IF_BASE + IF_SPD) : 5'b00000;
        pkt_type = acr_pending             ? PKT_ACR :
                   audio_ok                ? PKT_AUDIO_SAMPLE :
                   if_pending[IF_AVI]      ? PKT_AVI_IF :
                   if_pending[IF_AUDIO_IF] ? PKT_AUDIO_IF :
                   if_pending[IF_SPD]      ? PKT_SPD_IF : PKT_NULL;
    end

endmodule

// File: rtl/packet_scheduler.sv
// packet_scheduler: per-slot HDMI data-island scheduler for ACR, audio samples and InfoFrames.
//   clk_pixel, reset_n      : pixel clock, asynchronous active-low reset
//   packet_enable           : a new packet slot starts this cycle
//   frame_start             : re-arms the enabled InfoFrames once per frame
//   clk_audio_counter_wrap  : toggle from the ACR generator, each edge is one request
//   audio_sample_valid      : audio sample packet available (sampled at slot start)
//   packet_type             : selected packet type, held until the next accepted slot
//   acr_grant, audio_grant, infoframe_grant : one-cycle grants to the chosen source
//   acr_overrun             : sticky, ACR edge arrived while one was still pending
//   slot_error              : sticky, packet_enable arrived before the slot ended
module packet_scheduler
    import hdmi_packet_pkg::*;
#(
    parameter int         AUDIO_BURST_MAX  = 4,
    parameter logic [2:0] INFOFRAME_ENABLE = 3'b111,
    parameter int         SLOT_CYCLES      = 32
) (
    input  logic       clk_pixel,
    input  logic       reset_n,
    input  logic       packet_enable,
    input  logic       frame_start,
    input  logic       clk_audio_counter_wrap,
    input  logic       audio_sample_valid,
    output pkt_type_t  packet_type,
    output logic       acr_grant,
    output logic       audio_grant,
    output logic [2:0] infoframe_grant,
    output logic       acr_overrun,
    output logic       slot_error
);

    logic       wrap_q;
    logic       acr_pending;
    logic [2:0] if_pending;
    logic [3:0] burst_cnt;
    logic [4:0] slot_cnt;
    logic       acr_edge;
    logic       accept;
    logic       burst_limit;
    logic [4:0] winner;
    logic [4:0] grant_now;
    pkt_type_t  sel_type;

    assign acr_edge    = clk_audio_counter_wrap ^ wrap_q;
    assign accept      = packet_enable && slot_cnt == '0;
    assign burst_limit = burst_cnt == 4'(AUDIO_BURST_MAX) && |if_pending;
    assign grant_now   = accept ? winner : 5'b00000;

    packet_priority_select u_select (
        .acr_pending (acr_pending),
        .audio_valid (audio_sample_valid),
        .burst_limit (burst_limit),
        .if_pending  (if_pending),
        .winner      (winner),
        .pkt_type    (sel_type)
    );

    // New requests take precedence over a same-cycle grant, so pending stays set
    always_ff @(posedge clk_pixel or negedge reset_n) begin
        if (!reset_n) begin
            wrap_q          <= 1'b0;
            acr_pending     <= 1'b0;
            if_pending      <= 3'b000;
            burst_cnt       <= 4'd0;
            slot_cnt        <= 5'd0;
            packet_type     <= PKT_NULL;
            acr_grant       <= 1'b0;
            audio_grant     <= 1'b0;
            infoframe_grant <= 3'b000;
            acr_overrun     <= 1'b0;
            slot_error      <= 1'b0;
        end else begin
            wrap_q          <= clk_audio_counter_wrap;
            acr_pending     <= acr_edge | (acr_pending & ~grant_now[WIN_ACR]);
            acr_overrun     <= acr_overrun | (acr_edge & acr_pending & ~grant_now[WIN_ACR]);
            if_pending      <= (frame_start ? INFOFRAME_ENABLE : 3'b000) | (if_pending & ~grant_now[4:2]);
            acr_grant       <= grant_now[WIN_ACR];
            audio_grant     <= grant_now[WIN_AUDIO];
            infoframe_grant <= grant_now[4:2];
            slot_error      <= slot_error | (packet_enable & ~accept);
            slot_cnt        <= accept ? 5'(SLOT_CYCLES - 1) : slot_cnt != '0 ? slot_cnt - 5'd1 : slot_cnt;
            if (accept) begin
                packet_type <= sel_type;
                burst_cnt   <= winner[WIN_AUDIO] ? (burst_cnt >= 4'(AUDIO_BURST_MAX) ? burst_cnt : burst_cnt + 4'd1) :
                               winner[WIN_ACR]   ? burst_cnt : 4'd0;
            end
        end
    end

endmodule

// File: tb/tb_packet_scheduler.sv
// tb_packet_scheduler: directed scenarios plus randomized traffic checked against a slot-level reference model.
module tb_packet_scheduler;

    localparam int         BURST = 4;
    localparam logic [2:0] IFEN  = 3'b111;
    localparam int         SLOT  = 32;

    logic       clk_pixel = 1'b0;
    logic       reset_n   = 1'b0;
    logic       pe = 1'b0, fs = 1'b0, wrap = 1'b0, asv = 1'b0;
    logic [7:0] packet_type;
    logic       acr_grant, audio_grant, acr_overrun, slot_error;
    logic [2:0] infoframe_grant;

    int checks = 0;
    int errors = 0;

    // Reference model state: age counts cycles since the last accepted slot
    int         m_age;
    bit         m_wrap, m_acr, m_over, m_err, m_acr_g, m_aud_g;
    bit   [2:0] m_if, m_if_g;
    int         m_burst;
    logic [7:0] m_type;

    logic [7:0] if_seq [15] = '{8'h02, 8'h02, 8'h02, 8'h02, 8'h82, 8'h02, 8'h02, 8'h02,
                                8'h02, 8'h84, 8'h02, 8'h02, 8'h02, 8'h02, 8'h83};

    always #5 clk_pixel = ~clk_pixel;

    packet_scheduler #(
        .AUDIO_BURST_MAX  (BURST),
        .INFOFRAME_ENABLE (IFEN),
        .SLOT_CYCLES      (SLOT)
    ) dut (
        .clk_pixel              (clk_pixel),
        .reset_n                (reset_n),
        .packet_enable          (pe),
        .frame_start            (fs),
        .clk_audio_counter_wrap (wrap),
        .audio_sample_valid     (asv),
        .packet_type            (packet_type),
        .acr_grant              (acr_grant),
        .audio_grant            (audio_grant),
        .infoframe_grant        (infoframe_grant),
        .acr_overrun            (acr_overrun),
        .slot_error             (slot_error)
    );

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_age = SLOT; m_wrap = 0; m_acr = 0; m_over = 0; m_err = 0;
        m_acr_g = 0; m_aud_g = 0; m_if = 0; m_if_g = 0; m_burst = 0; m_type = 8'h00;
    endtask

    task automatic model_update();
        bit ev, acc;
        ev  = wrap != m_wrap;
        acc = pe && m_age >= SLOT;
        m_acr_g = 0; m_aud_g = 0; m_if_g = 0;
        if (acc) begin
            if (m_acr) begin
                m_acr_g = 1; m_type = 8'h01;
            end else if (asv && !(m_burst == BURST && m_if != 0)) begin
                m_aud_g = 1; m_type = 8'h02; m_burst = m_burst < BURST ? m_burst + 1 : m_burst;
            end else if (m_if[0]) begin
                m_if_g = 3'b001; m_type = 8'h82; m_burst = 0;
            end else if (m_if[2]) begin
                m_if_g = 3'b100; m_type = 8'h84; m_burst = 0;
            end else if (m_if[1]) begin
                m_if_g = 3'b010; m_type = 8'h83; m_burst = 0;
            end else begin
                m_type = 8'h00; m_burst = 0;
            end
        end
        m_over = m_over || (ev && m_acr && !m_acr_g);
        m_acr  = ev || (m_acr && !m_acr_g);
        m_if   = (fs ? IFEN : 3'b000) | (m_if & ~m_if_g);
        m_err  = m_err || (pe && !acc);
        m_age  = acc ? 1 : (m_age < 1000 ? m_age + 1 : m_age);
        m_wrap = wrap;
    endtask

    task automatic step();
        @(posedge clk_pixel);
        if (!reset_n) model_reset(); else model_update();
        #1;
        check("packet_type", 16'(packet_type), 16'(m_type));
        check("acr_grant", 16'(acr_grant), 16'(m_acr_g));
        check("audio_grant", 16'(audio_grant), 16'(m_aud_g));
        check("infoframe_grant", 16'(infoframe_grant), 16'(m_if_g));
        check("acr_overrun", 16'(acr_overrun), 16'(m_over));
        check("slot_error", 16'(slot_error), 16'(m_err));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic slot();
        pe = 1; step(); pe = 0;
    endtask

    // Asserted mid-cycle so the outputs are seen clearing without a clock edge
    task automatic do_reset();
        pe = 0; fs = 0; wrap = 0; asv = 0;
        #2 reset_n = 0;
        #1;
        check("async_rst_type", 16'(packet_type), 16'h00);
        check("async_rst_grants", 16'({acr_grant, audio_grant, infoframe_grant}), 16'h0);
        check("async_rst_flags", 16'({acr_overrun, slot_error}), 16'h0);
        model_reset();
        idle(2);
        reset_n = 1;
    endtask

    initial begin
        model_reset();
        idle(2);
        reset_n = 1;
        step();
        // Empty slot yields a null packet
        slot();
        check("tp_null_type", 16'(packet_type), 16'h00);
        check("tp_null_err", 16'(slot_error), 16'h0);
        idle(SLOT - 1);
        // ACR beats a waiting audio sample, audio follows next slot
        wrap = 1; idle(5);
        asv = 1; slot();
        check("tp_acr_type", 16'(packet_type), 16'h01);
        check("tp_acr_grant", 16'(acr_grant), 16'h1);
        step();
        check("tp_acr_pulse", 16'(acr_grant), 16'h0);
        idle(SLOT - 2);
        slot();
        check("tp_audio_type", 16'(packet_type), 16'h02);
        check("tp_audio_grant", 16'(audio_grant), 16'h1);
        idle(SLOT - 1);
        // Audio burst limit lets InfoFrames through one at a time
        do_reset();
        asv = 1; fs = 1; step(); fs = 0;
        for (int k = 0; k < 15; k++) begin
            slot();
            check($sformatf("tp_if_seq%0d", k), 16'(packet_type), 16'(if_seq[k]));
            idle(SLOT - 1);
        end
        // Two ACR edges before a slot: overrun, then a single ACR grant
        do_reset();
        wrap = 1; step(); step(); wrap = 0; step();
        check("tp_overrun", 16'(acr_overrun), 16'h1);
        slot();
        check("tp_ovr_acr", 16'(acr_grant), 16'h1);
        idle(SLOT - 1);
        slot();
        check("tp_ovr_single", 16'(packet_type), 16'h00);
        check("tp_ovr_sticky", 16'(acr_overrun), 16'h1);
        idle(SLOT - 1);
        // Early packet_enable is ignored and flagged, offset 32 is accepted
        do_reset();
        slot();
        idle(9);
        asv = 1; slot();
        check("tp_early_type", 16'(packet_type), 16'h00);
        check("tp_early_grant", 16'(audio_grant), 16'h0);
        check("tp_early_err", 16'(slot_error), 16'h1);
        idle(21);
        slot();
        check("tp_boundary_type", 16'(packet_type), 16'h02);
        idle(SLOT - 1);
        // Reset in the middle of an AVI slot drops the pending SPD
        do_reset();
        fs = 1; step(); fs = 0;
        slot();
        check("tp_avi_type", 16'(packet_type), 16'h82);
        idle(4);
        do_reset();
        slot();
        check("tp_post_rst_type", 16'(packet_type), 16'h00);
        idle(SLOT - 1);
        // Randomized traffic against the model
        for (int c = 0; c < 6000; c++) begin
            if ($urandom_range(0, 1999) == 0) do_reset();
            pe = ($urandom_range(0, 15) == 0) || ((m_age == SLOT - 1 || m_age == SLOT) && $urandom_range(0, 1) == 1);
            fs = $urandom_range(0, 199) == 0;
            if ($urandom_range(0, 59) == 0) wrap = ~wrap;
            if ($urandom_range(0, 9) == 0) asv = ~asv;
            step();
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
